// File: rtl/pmux_result_fifo_if.sv
// rtl/pmux_result_fifo_if.sv - producer/consumer handshake bundle for the result FIFO
interface pmux_result_fifo_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             in_ready;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic             out_ready;

   // Environment side: drives the producer and consumer controls.
   modport master (
      output in_valid,
      output in_data,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_data
   );

   // FIFO side.
   modport slave (
      input  in_valid,
      input  in_data,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_data
   );
endinterface

// File: rtl/pmux_result_fifo.sv
// rtl/pmux_result_fifo.sv - first-word-fall-through capture FIFO with checksum and accept counter
module pmux_result_fifo #(
   parameter int WIDTH  = 16,
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   pmux_result_fifo_if.slave   bus,
   input  logic                clr,
   output logic [ADDR_W:0]     count,
   output logic [WIDTH-1:0]    checksum,
   output logic [15:0]         accepted,
   output logic                drop_err
);

   localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

   logic [WIDTH-1:0]  mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic              push;
   logic              pop;

   // Flow control comes from registered occupancy only, so no input reaches an output combinationally.
   assign bus.in_ready  = (count != FULL_CNT);
   assign bus.out_valid = (count != '0);
   assign bus.out_data  = mem[rd_ptr];

   assign push = bus.in_valid  && bus.in_ready;
   assign pop  = bus.out_valid && bus.out_ready;

   // Storage array is not reset; its contents are only observed while out_valid is high.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= bus.in_data;
      end
   end

   // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Running checksum and accept counter; a same-cycle clear zeroes first, then the push accumulates.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         checksum <= '0;
         accepted <= '0;
      end else if (push) begin
         checksum <= (clr ? '0 : checksum) + bus.in_data;
         accepted <= (clr ? 16'd0 : accepted) + 16'd1;
      end else if (clr) begin
         checksum <= '0;
         accepted <= '0;
      end
   end

   // Sticky overflow flag: any offered value that the full FIFO had to refuse; only reset clears it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_err <= 1'b0;
      end else if (bus.in_valid && !bus.in_ready) begin
         drop_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_pmux_result_fifo.sv
// tb/tb_pmux_result_fifo.sv - self-checking bench for pmux_result_fifo
module tb_pmux_result_fifo;

   localparam int DEPTH = 4;

   logic        clk;
   logic        rst_n;
   logic        clr;
   logic [2:0]  count;
   logic [15:0] checksum;
   logic [15:0] accepted;
   logic        drop_err;

   pmux_result_fifo_if #(.WIDTH(16)) bus ();

   pmux_result_fifo #(.WIDTH(16), .DEPTH(4), .ADDR_W(2)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus),
      .clr      (clr),
      .count    (count),
      .checksum (checksum),
      .accepted (accepted),
      .drop_err (drop_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec;
   int n_err;

   // Reference model state: FIFO contents as a queue plus the running totals.
   logic [15:0] m_q[$];
   logic [15:0] m_sum;
   logic [15:0] m_acc;
   logic        m_drop;

   typedef struct {
      logic        iv;
      logic [15:0] id;
      logic        ordy;
      logic        c;
      logic [2:0]  e_count;
      logic [15:0] e_sum;
      logic [15:0] e_acc;
      logic        e_ready;
      logic        e_valid;
      logic [15:0] e_data;
      logic        e_drop;
   } vec_t;

   vec_t tbl[20];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      m_q.delete();
      m_sum  = 16'h0000;
      m_acc  = 16'h0000;
      m_drop = 1'b0;
   endtask

   task automatic do_reset();
      bus.in_valid  = 1'b0;
      bus.in_data   = 16'h0000;
      bus.out_ready = 1'b0;
      clr           = 1'b0;
      rst_n         = 1'b0;
      #3;
      chk("rst_count",    32'(count),         32'd0);
      chk("rst_in_ready", 32'(bus.in_ready),  32'd1);
      chk("rst_out_vld",  32'(bus.out_valid), 32'd0);
      chk("rst_checksum", 32'(checksum),      32'd0);
      chk("rst_accepted", 32'(accepted),      32'd0);
      chk("rst_drop_err", 32'(drop_err),      32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_clear();
   endtask

   // One clock of stimulus: compare the current DUT state with the model, then advance both.
   task automatic step(input logic iv, input logic [15:0] d, input logic ordy, input logic c);
      bit full;
      bit do_push;
      bit do_pop;
      bus.in_valid  = iv;
      bus.in_data   = d;
      bus.out_ready = ordy;
      clr           = c;
      full = (m_q.size() >= DEPTH);
      chk("count",     32'(count),         32'(m_q.size()));
      chk("in_ready",  32'(bus.in_ready),  32'(!full));
      chk("out_valid", 32'(bus.out_valid), 32'(m_q.size() > 0));
      if (m_q.size() > 0) chk("out_data", 32'(bus.out_data), 32'(m_q[0]));
      chk("checksum",  32'(checksum),      32'(m_sum));
      chk("accepted",  32'(accepted),      32'(m_acc));
      chk("drop_err",  32'(drop_err),      32'(m_drop));
      do_push = iv && !full;
      do_pop  = ordy && (m_q.size() > 0);
      if (iv && full) m_drop = 1'b1;
      if (c) begin
         m_sum = 16'h0000;
         m_acc = 16'h0000;
      end
      if (do_push) begin
         m_sum = m_sum + d;
         m_acc = m_acc + 16'd1;
      end
      if (do_pop) void'(m_q.pop_front());
      if (do_push) m_q.push_back(d);
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rst_n = 1'b0;
      model_clear();

      //            iv    data      ordy  clr   cnt   sum       acc     rdy   vld   data      drop
      tbl[0]  = '{1'b1, 16'h0003, 1'b0, 1'b0, 3'd1, 16'h0003, 16'd1, 1'b1, 1'b1, 16'h0003, 1'b0};
      tbl[1]  = '{1'b1, 16'h0005, 1'b0, 1'b0, 3'd2, 16'h0008, 16'd2, 1'b1, 1'b1, 16'h0003, 1'b0};
      tbl[2]  = '{1'b1, 16'h0007, 1'b0, 1'b0, 3'd3, 16'h000F, 16'd3, 1'b1, 1'b1, 16'h0003, 1'b0};
      tbl[3]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 3'd2, 16'h000F, 16'd3, 1'b1, 1'b1, 16'h0005, 1'b0};
      tbl[4]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 3'd1, 16'h000F, 16'd3, 1'b1, 1'b1, 16'h0007, 1'b0};
      tbl[5]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 3'd0, 16'h000F, 16'd3, 1'b1, 1'b0, 16'h0000, 1'b0};
      tbl[6]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 3'd0, 16'h0000, 16'd0, 1'b1, 1'b0, 16'h0000, 1'b0};
      tbl[7]  = '{1'b1, 16'hFFFF, 1'b0, 1'b0, 3'd1, 16'hFFFF, 16'd1, 1'b1, 1'b1, 16'hFFFF, 1'b0};
      tbl[8]  = '{1'b1, 16'h0001, 1'b0, 1'b0, 3'd2, 16'h0000, 16'd2, 1'b1, 1'b1, 16'hFFFF, 1'b0};
      tbl[9]  = '{1'b1, 16'h1234, 1'b0, 1'b0, 3'd3, 16'h1234, 16'd3, 1'b1, 1'b1, 16'hFFFF, 1'b0};
      tbl[10] = '{1'b1, 16'h0000, 1'b0, 1'b0, 3'd4, 16'h1234, 16'd4, 1'b0, 1'b1, 16'hFFFF, 1'b0};
      tbl[11] = '{1'b1, 16'hAAAA, 1'b0, 1'b0, 3'd4, 16'h1234, 16'd4, 1'b0, 1'b1, 16'hFFFF, 1'b1};
      tbl[12] = '{1'b1, 16'hBBBB, 1'b1, 1'b0, 3'd3, 16'h1234, 16'd4, 1'b1, 1'b1, 16'h0001, 1'b1};
      tbl[13] = '{1'b1, 16'h5555, 1'b0, 1'b0, 3'd4, 16'h6789, 16'd5, 1'b0, 1'b1, 16'h0001, 1'b1};
      tbl[14] = '{1'b0, 16'h0000, 1'b1, 1'b0, 3'd3, 16'h6789, 16'd5, 1'b1, 1'b1, 16'h1234, 1'b1};
      tbl[15] = '{1'b1, 16'h0042, 1'b0, 1'b1, 3'd4, 16'h0042, 16'd1, 1'b0, 1'b1, 16'h1234, 1'b1};
      tbl[16] = '{1'b0, 16'h0000, 1'b1, 1'b1, 3'd3, 16'h0000, 16'd0, 1'b1, 1'b1, 16'h0000, 1'b1};
      tbl[17] = '{1'b0, 16'h0000, 1'b1, 1'b0, 3'd2, 16'h0000, 16'd0, 1'b1, 1'b1, 16'h5555, 1'b1};
      tbl[18] = '{1'b0, 16'h0000, 1'b1, 1'b0, 3'd1, 16'h0000, 16'd0, 1'b1, 1'b1, 16'h0042, 1'b1};
      tbl[19] = '{1'b0, 16'h0000, 1'b1, 1'b0, 3'd0, 16'h0000, 16'd0, 1'b1, 1'b0, 16'h0000, 1'b1};

      do_reset();

      // Directed table: fill, drain, overflow, clear-with-push.
      for (int i = 0; i < 20; i++) begin
         bus.in_valid  = tbl[i].iv;
         bus.in_data   = tbl[i].id;
         bus.out_ready = tbl[i].ordy;
         clr           = tbl[i].c;
         @(posedge clk);
         #1;
         chk($sformatf("t%0d_count", i),    32'(count),         32'(tbl[i].e_count));
         chk($sformatf("t%0d_checksum", i), 32'(checksum),      32'(tbl[i].e_sum));
         chk($sformatf("t%0d_accepted", i), 32'(accepted),      32'(tbl[i].e_acc));
         chk($sformatf("t%0d_in_ready", i), 32'(bus.in_ready),  32'(tbl[i].e_ready));
         chk($sformatf("t%0d_out_vld", i),  32'(bus.out_valid), 32'(tbl[i].e_valid));
         if (tbl[i].e_valid)
            chk($sformatf("t%0d_out_data", i), 32'(bus.out_data), 32'(tbl[i].e_data));
         chk($sformatf("t%0d_drop_err", i), 32'(drop_err),      32'(tbl[i].e_drop));
      end

      // Steady push+pop at occupancy 2 across pointer wrap.
      do_reset();
      step(1'b1, 16'hC000, 1'b0, 1'b0);
      step(1'b1, 16'hC001, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 16'hC002 + 16'(i), 1'b1, 1'b0);
         chk("pp_count", 32'(count), 32'd2);
      end
      for (int i = 0; i < 3; i++) step(1'b0, 16'h0000, 1'b1, 1'b0);

      // Randomized traffic against the queue model.
      do_reset();
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(0, 9) < 6),
              16'($urandom),
              1'($urandom_range(0, 9) < 5),
              1'($urandom_range(0, 15) == 0));
      end

      // Asynchronous reset in the middle of a burst at occupancy 3.
      do_reset();
      step(1'b1, 16'h0101, 1'b0, 1'b0);
      step(1'b1, 16'h0202, 1'b0, 1'b0);
      step(1'b1, 16'h0303, 1'b0, 1'b0);
      step(1'b1, 16'h0404, 1'b0, 1'b0);
      step(1'b1, 16'h0505, 1'b0, 1'b0);
      step(1'b0, 16'h0000, 1'b1, 1'b0);
      chk("mid_count_pre", 32'(count),    32'd3);
      chk("mid_drop_pre",  32'(drop_err), 32'd1);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_count",    32'(count),         32'd0);
      chk("mid_out_vld",  32'(bus.out_valid), 32'd0);
      chk("mid_in_ready", 32'(bus.in_ready),  32'd1);
      chk("mid_checksum", 32'(checksum),      32'd0);
      chk("mid_accepted", 32'(accepted),      32'd0);
      chk("mid_drop_err", 32'(drop_err),      32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_clear();
      step(1'b1, 16'h7777, 1'b0, 1'b0);
      step(1'b0, 16'h0000, 1'b1, 1'b0);
      step(1'b0, 16'h0000, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/pmux_result_fifo.md
Name: pmux_result_fifo

Overview:
- Downstream capture stage for the 16-bit priority-mux result `q_o`.
- Accepts one result per cycle on a valid/ready handshake and buffers it in a small first-word-fall-through FIFO for a slower consumer.
- Keeps a running 16-bit wrap-around checksum and a count of accepted results, so a bench or downstream logic can confirm every selected result arrived in order.

Parameters:
- WIDTH, 16, data width; matches the mux output width.
- DEPTH, 4, number of FIFO entries; must be a power of two, at least 2.
- ADDR_W, 2, pointer width; equals log2(DEPTH).

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream result (q_o) is valid this cycle.
- in_data  input  WIDTH  upstream result value.
- in_ready  output  1  FIFO can accept an entry; equals not full.
- out_valid  output  1  FIFO holds at least one entry.
- out_data  output  WIDTH  head entry, readable combinationally from the head slot.
- out_ready  input  1  consumer takes the head entry this cycle.
- clr  input  1  synchronous clear of checksum and accept counter only.
- count  output  ADDR_W+1  current occupancy, 0..DEPTH.
- checksum  output  WIDTH  sum of all accepted in_data values, mod 2^WIDTH.
- accepted  output  16  number of accepted pushes, wraps at 65535 -> 0.
- drop_err  output  1  sticky flag; set when in_valid=1 while in_ready=0.

Behaviour:
- Reset (rst_n=0, async assert): wr_ptr=0, rd_ptr=0, count=0, checksum=0, accepted=0, drop_err=0. This gives in_ready=1 and out_valid=0. Memory contents are not reset; out_data is don't-care while out_valid=0.
- Reset release is synchronous to clk. The first push is possible on the first rising edge with rst_n=1.
- Push: in_valid && in_ready. Write in_data to mem[wr_ptr] and increment wr_ptr, wrapping mod DEPTH.
- Pop: out_valid && out_ready. Increment rd_ptr, wrapping mod DEPTH.
- Occupancy:
  - push only: count+1
  - pop only: count-1
  - push and pop together: count unchanged
- Full (count==DEPTH): in_ready=0. There is no write-through; a pop this cycle frees the slot from the next cycle onward.
- Empty (count==0): out_valid=0. There is no bypass, so a pushed value first appears on out_data one cycle after the push edge (latency 1).
- out_valid and in_ready are derived from the registered count only, never from same-cycle inputs. There are no combinational in-to-out paths.
- checksum: on each push, checksum <= checksum + in_data, truncated to WIDTH bits.
- accepted: on each push, accepted <= accepted + 1, wraps.
- clr=1:
  - checksum and accepted load 0, or load in_data and 1 if a push happens in the same cycle (clr applies first, then the push accumulates).
  - Does not touch FIFO contents, pointers, or drop_err.
- drop_err: set on any cycle with in_valid=1 and in_ready=0. Cleared only by reset; clr does not clear it.
- Reset mid-operation: all state returns to reset values immediately. Buffered entries are discarded.

Test Plan:
1. Reset, then push 0x0003, 0x0005, 0x0007 on consecutive cycles with out_ready=0 -> count=3, checksum=0x000F, accepted=3, out_data=0x0003.
2. With those 3 entries, hold out_ready=1 -> out_data reads 0x0003, 0x0005, 0x0007 on successive cycles; count reaches 0; out_valid=0 after the third pop.
3. Push 4 entries 0xFFFF, 0x0001, 0x1234, 0x0000 -> count=4, in_ready=0, checksum=0x1234. Drive in_valid=1 with 0xAAAA one more cycle -> drop_err=1 and checksum unchanged. Then pop once, and a push on the following cycle is accepted.
4. Simultaneous push and pop at count=2 for 8 cycles -> count stays 2; rd_ptr/wr_ptr wrap past 3 -> 0; output order matches input order.
5. Assert clr together with a push of 0x0042 -> checksum=0x0042, accepted=1, FIFO contents intact.
6. Assert rst_n=0 mid-stream at count=3 -> count=0, out_valid=0, in_ready=1, checksum=0, drop_err=0 before the next clk edge.
